aer_event_fifo: RTL
===================

Name: aer_event_fifo

Overview:
- Downstream stage of the GALS pixel encoder.
- Accepts AER spike events (time, address, frame-last tag) over a same-cycle req/ack interface.
- Drops late events outside a programmable time window and buffers the rest in a first-word-fall-through FIFO.
- Presents events to the first SNN layer over valid/ready and reports frame completion.

Parameters:
- VEC_LEN, 320, number of input neurons; address width ADDR_W = $clog2(VEC_LEN) = 9.
- TIME_W, 32, signed spike-time width.
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- T_WINDOW, 32'sh0000_0100, signed; events with time >= T_WINDOW are filtered.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- local_clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_aer_req  in  1  event offered; combinational from upstream.
- o_aer_ack  out  1  event accepted this cycle; combinational.
- i_aer_time  in  TIME_W  signed spike time.
- i_aer_addr  in  ADDR_W  neuron address.
- i_aer_last  in  1  event is the final event of a frame.
- i_flush  in  1  synchronous clear.
- o_evt_valid  out  1  head entry available.
- i_evt_ready  in  1  consumer takes head entry.
- o_evt_time  out  TIME_W  head time.
- o_evt_addr  out  ADDR_W  head address.
- o_evt_last  out  1  head last tag.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_full  out  1  occupancy == DEPTH.
- o_drop_cnt  out  DROP_W  filtered-event count, saturating.
- o_frame_done  out  1  one-cycle pulse after the last event of a frame is popped.
- o_frame_cnt  out  16  completed frames, wraps.

Behaviour:
- Reset (rst_n low, async): pointers, o_count, o_drop_cnt, o_frame_cnt and o_frame_done = 0.
  - Outputs while reset: o_aer_ack = 0, o_evt_valid = 0, o_full = 0.
  - The memory array is not reset.
- Reset mid-transfer discards all buffered events. Upstream sees ack = 0 and holds its request.
- Accept rule: o_aer_ack = !o_full && !i_flush && rst_n.
  - Ack does not depend on i_aer_req and is not registered.
  - Upstream advances on req && ack in the same cycle.
- Transfer = i_aer_req && o_aer_ack, sampled at the posedge.
- Filter: a transfer is stored unless ($signed(i_aer_time) >= T_WINDOW && !i_aer_last).
  - Events with i_aer_last = 1 are always stored, so frame boundaries are never lost.
- A filtered transfer is still acked and not written. It increments o_drop_cnt, which saturates at 2^DROP_W-1.
- FWFT read side:
  - o_evt_valid = (o_count != 0).
  - o_evt_time/addr/last show the head entry combinationally from the read pointer.
  - These outputs are forced to 0 when empty.
- Pop = o_evt_valid && i_evt_ready; read pointer advances at the posedge.
- Write and read pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Count update:
  - store only: +1.
  - pop only: -1.
  - store and pop in the same cycle: unchanged. Both pointers advance.
- When full, ack = 0 even if a pop occurs in the same cycle. There is no write-through on full.
- Empty with a simultaneous store: the entry becomes visible the next cycle. Write-to-valid latency is 1 cycle.
- Frame completion:
  - Popping an entry with last = 1 registers o_frame_done = 1 for exactly one cycle (the cycle after the pop).
  - o_frame_cnt increments on that same edge; 16'hFFFF wraps to 0.
- i_flush (sync, level, takes effect at the posedge):
  - Clears the pointers, o_count and o_drop_cnt.
  - Suppresses ack in that cycle.
  - Suppresses frame_done for any pop in that cycle.
  - o_frame_cnt is preserved.
- Flush and reset both override push and pop.
- Implementation: a single always block for pointers and counters, plus combinational ack, valid and head select.

Test Plan:
- After reset, push 3 events with ready = 0: (time 5, addr 0), (time 7, addr 17), (time 0x20, addr 319, last = 1).
  - Required: o_count = 3, o_evt_valid = 1, head = time 5 / addr 0.
  - Raise ready: pops in order over 3 cycles. o_frame_done pulses once, the cycle after the third pop. o_frame_cnt = 1.
- Filter:
  - Push time = 0x100 (last = 0): acked, not stored, o_drop_cnt = 1, o_count unchanged.
  - Push time = 0x100 with last = 1: stored.
  - Push time = -3: stored (signed compare).
- Full/backpressure: hold ready = 0 and push 17 events.
  - Required: first 16 acked; o_full = 1 and o_aer_ack = 0 on the 17th.
  - Assert ready for 1 cycle with req high: no ack that cycle. Ack returns the next cycle. Count ends at 16.
- Simultaneous push and pop with count = 8 for 20 cycles:
  - Required: count stays 8, pointers wrap past 15 -> 0, output order is preserved.
- i_flush with count = 5 and o_drop_cnt = 2:
  - Required: next cycle count = 0, valid = 0, drop_cnt = 0, frame_cnt unchanged, ack low during the flush cycle.
- Async reset mid-stream (count = 4, req high): immediate ack = 0, valid = 0. After release, ack = 1 and the first new event is stored at entry 0.

Source files
------------

// File: rtl/aer_event_fifo.sv
// -----------------------------------------------------------------------------
// aer_event_fifo
//   Buffers AER spike events coming out of the GALS pixel encoder and hands
//   them to the first SNN layer. Late events (time >= T_WINDOW) are dropped
//   and counted unless they carry the frame-last tag. Storage is a
//   first-word-fall-through FIFO; popping a frame-last event raises a
//   one-cycle frame_done pulse and bumps the frame counter.
//
// Ports
//   local_clk, rst_n      clock, asynchronous active-low reset
//   i_aer_req/o_aer_ack   same-cycle handshake from the encoder (ack is comb.)
//   i_aer_time/addr/last  offered event (signed time, neuron address, tag)
//   i_flush               synchronous clear of FIFO and drop counter
//   o_evt_valid/i_evt_ready  FWFT head handshake toward the SNN layer
//   o_evt_time/addr/last  head entry, zero while empty
//   o_count, o_full       occupancy
//   o_drop_cnt            saturating count of filtered events
//   o_frame_done          pulse the cycle after a frame-last pop
//   o_frame_cnt           wrapping count of completed frames
// -----------------------------------------------------------------------------
module aer_event_fifo #(
    parameter int                        VEC_LEN  = 320,
    parameter int                        ADDR_W   = $clog2(VEC_LEN),
    parameter int                        TIME_W   = 32,
    parameter int                        DEPTH    = 16,
    parameter logic signed [TIME_W-1:0]  T_WINDOW = 32'sh0000_0100,
    parameter int                        DROP_W   = 16,
    parameter int                        CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                     local_clk,
    input  logic                     rst_n,
    input  logic                     i_aer_req,
    output logic                     o_aer_ack,
    input  logic signed [TIME_W-1:0] i_aer_time,
    input  logic [ADDR_W-1:0]        i_aer_addr,
    input  logic                     i_aer_last,
    input  logic                     i_flush,
    output logic                     o_evt_valid,
    input  logic                     i_evt_ready,
    output logic signed [TIME_W-1:0] o_evt_time,
    output logic [ADDR_W-1:0]        o_evt_addr,
    output logic                     o_evt_last,
    output logic [CNT_W-1:0]         o_count,
    output logic                     o_full,
    output logic [DROP_W-1:0]        o_drop_cnt,
    output logic                     o_frame_done,
    output logic [15:0]              o_frame_cnt
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                ENTRY_W  = TIME_W + ADDR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [DROP_W-1:0]    r_drop_cnt;
    logic                 r_frame_done;
    logic [15:0]          r_frame_cnt;

    logic                 w_xfer;
    logic                 w_late;
    logic                 w_store;
    logic                 w_drop;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_head;
    logic                 w_head_last;

    // Ack is independent of req so the encoder can decide in the same cycle.
    assign o_full      = (r_count == FULL_CNT);
    assign o_aer_ack   = !o_full && !i_flush && rst_n;
    assign o_evt_valid = (r_count != '0);

    assign w_xfer  = i_aer_req && o_aer_ack;
    // Frame-last events bypass the window so frame boundaries survive.
    assign w_late  = (i_aer_time >= T_WINDOW) && !i_aer_last;
    assign w_store = w_xfer && !w_late;
    assign w_drop  = w_xfer && w_late;
    assign w_pop   = o_evt_valid && i_evt_ready;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_last = w_head[ENTRY_W-1];

    assign o_evt_time = o_evt_valid ? $signed(w_head[TIME_W-1:0]) : '0;
    assign o_evt_addr = o_evt_valid ? w_head[TIME_W +: ADDR_W]    : '0;
    assign o_evt_last = o_evt_valid && w_head_last;

    assign o_count      = r_count;
    assign o_drop_cnt   = r_drop_cnt;
    assign o_frame_done = r_frame_done;
    assign o_frame_cnt  = r_frame_cnt;

    // Storage carries no reset; stale contents are never visible because
    // the head outputs are masked whenever the FIFO is empty.
    always_ff @(posedge local_clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= {i_aer_last, i_aer_addr, i_aer_time};
        end
    end

    always_ff @(posedge local_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else if (i_flush) begin
            // Frame count is kept across a flush; a pop this cycle is void.
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
            r_frame_done <= w_pop && w_head_last;
            if (w_pop && w_head_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

endmodule
